// File: rtl/exp1_sequencer.sv
// exp1_sequencer
//
// Self-test sequencer for the experiment-1 gate datapath. It sweeps the
// datapath through five configurations (taskMode/subtaskMode) and all eight
// {a,b,c} input combinations. Each vector is held for DWELL_CYCLES cycles,
// and the datapath outputs are then sampled for one cycle and compared
// against a built-in golden model. The result of the sweep is reported as
// pass/fail, an error count and the first failing vector.
//
// Parameters
//   DWELL_CYCLES  cycles each vector is held before sampling (1..255)
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous, active-high reset
//   start                    one-cycle pulse; begins a sweep from IDLE or DONE
//   abort                    level; forces IDLE on the next edge
//   stepMode                 1 = pause in HOLD after every sampled vector
//   step                     one-cycle pulse; leaves HOLD for the next vector
//   l1In,l2In,xIn,yIn,zIn    datapath outputs under test
//   taskMode, subtaskMode    datapath mode drive
//   a, b, c                  datapath input drive ({a,b,c} = vector index)
//   busy                     high in APPLY, SAMPLE and HOLD
//   done                     high in DONE
//   pass                     1 in DONE when no vector failed
//   errCount                 failing vectors in the current sweep (0..40)
//   failCfg, failVec         configuration/vector of the first failure
//   failValid                a failure has been captured
module exp1_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       stepMode,
  input  logic       step,
  input  logic       l1In,
  input  logic       l2In,
  input  logic       xIn,
  input  logic       yIn,
  input  logic       zIn,
  output logic       taskMode,
  output logic [1:0] subtaskMode,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] errCount,
  output logic [2:0] failCfg,
  output logic [2:0] failVec,
  output logic       failValid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);
  localparam logic [2:0] LAST_CFG   = 3'd4;
  localparam logic [2:0] LAST_VEC   = 3'd7;

  state_t     state;
  logic [2:0] cfg;
  logic [2:0] vec;
  logic [7:0] dwell;

  // Golden model outputs for the vector currently held in cfg/vec.
  logic       va, vb, vc;
  logic       gl1, gl2, gx, gy, gz;
  logic       mismatch;
  logic [5:0] err_after;
  logic       last_vec;
  logic [2:0] cfg_adv;
  logic [2:0] vec_adv;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    va  = vec[2];
    vb  = vec[1];
    vc  = vec[0];
    gl1 = 1'b0;
    gl2 = 1'b0;
    gx  = 1'b0;
    gy  = 1'b0;
    gz  = 1'b0;
    if (cfg == LAST_CFG) begin
      gy = va | vb;
      gz = va | ~vb;
      gx = va | ~vb;
    end else begin
      // Odd configurations use OR for the first stage, even ones AND.
      gl1 = cfg[0] ? (va | vb) : (va & vb);
      case (cfg[1:0])
        2'd0:    gl2 = gl1 & vc;
        2'd1:    gl2 = gl1 | vc;
        2'd2:    gl2 = ~(gl1 & vc);
        default: gl2 = ~(gl1 | vc);
      endcase
    end
  end

  assign mismatch  = {l1In, l2In, xIn, yIn, zIn} != {gl1, gl2, gx, gy, gz};
  assign err_after = errCount + {5'd0, mismatch};
  assign last_vec  = (cfg == LAST_CFG) && (vec == LAST_VEC);
  // The vec 7 -> 0 wrap moves on to the next configuration.
  assign vec_adv   = vec + 3'd1;
  assign cfg_adv   = (vec == LAST_VEC) ? cfg + 3'd1 : cfg;

  // Packs {taskMode, subtaskMode, a, b, c} for a configuration/vector pair.
  function automatic logic [5:0] drive_bits(input logic [2:0] cfg_i,
                                            input logic [2:0] vec_i);
    drive_bits = (cfg_i == LAST_CFG) ? {1'b1, 2'b00, vec_i}
                                     : {1'b0, cfg_i[1:0], vec_i};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every register samples the pre-edge values of the others.
      state       <= ST_IDLE;
      cfg         <= 3'd0;
      vec         <= 3'd0;
      dwell       <= 8'd0;
      taskMode    <= 1'b0;
      subtaskMode <= 2'b00;
      a           <= 1'b0;
      b           <= 1'b0;
      c           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      errCount    <= 6'd0;
      failCfg     <= 3'd0;
      failVec     <= 3'd0;
      failValid   <= 1'b0;
    end else if (abort) begin
      // Results are deliberately kept so they can be read after an abort.
      state       <= ST_IDLE;
      cfg         <= 3'd0;
      vec         <= 3'd0;
      dwell       <= 8'd0;
      taskMode    <= 1'b0;
      subtaskMode <= 2'b00;
      a           <= 1'b0;
      b           <= 1'b0;
      c           <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_APPLY;
            cfg       <= 3'd0;
            vec       <= 3'd0;
            dwell     <= 8'd0;
            {taskMode, subtaskMode, a, b, c} <= drive_bits(3'd0, 3'd0);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            errCount  <= 6'd0;
            failCfg   <= 3'd0;
            failVec   <= 3'd0;
            failValid <= 1'b0;
          end
        end

        ST_APPLY: begin
          if (dwell == DWELL_LAST) begin
            state <= ST_SAMPLE;
            dwell <= 8'd0;
          end else begin
            dwell <= dwell + 8'd1;
          end
        end

        ST_SAMPLE: begin
          if (mismatch) begin
            errCount <= err_after;
            if (!failValid) begin
              failCfg   <= cfg;
              failVec   <= vec;
              failValid <= 1'b1;
            end
          end
          if (last_vec) begin
            // The final vector stays on the drive pins while in DONE.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_after == 6'd0);
          end else if (stepMode) begin
            state <= ST_HOLD;
          end else begin
            state <= ST_APPLY;
            cfg   <= cfg_adv;
            vec   <= vec_adv;
            {taskMode, subtaskMode, a, b, c} <= drive_bits(cfg_adv, vec_adv);
          end
        end

        ST_HOLD: begin
          if (step) begin
            state <= ST_APPLY;
            cfg   <= cfg_adv;
            vec   <= vec_adv;
            {taskMode, subtaskMode, a, b, c} <= drive_bits(cfg_adv, vec_adv);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp1_sequencer.sv
// Testbench for exp1_sequencer. A behavioural gate datapath (with an optional
// stuck-at-0 fault on l2) is attached to the sequencer's drive pins. Expected
// sweep results are pushed into a scoreboard when a sweep is started; a monitor
// pops and compares them whenever `done` rises.
module tb_exp1_sequencer;

  localparam int DWELL = 4;
  localparam int SWEEP = 1 + 40 * (DWELL + 1);  // cycles from start to done

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       stepMode;
  logic       step;
  logic       l1In, l2In, xIn, yIn, zIn;
  logic       taskMode;
  logic [1:0] subtaskMode;
  logic       a, b, c;
  logic       busy, done, pass;
  logic [5:0] errCount;
  logic [2:0] failCfg, failVec;
  logic       failValid;

  logic       fault_l2;
  int         cyc;
  int         n_checks;
  int         n_fail;

  typedef struct {
    int edge_no;
    int err;
    int fcfg;
    int fvec;
    int fvalid;
    int pass_v;
  } exp_t;

  exp_t sb[$];

  exp1_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .stepMode   (stepMode),
    .step       (step),
    .l1In       (l1In),
    .l2In       (l2In),
    .xIn        (xIn),
    .yIn        (yIn),
    .zIn        (zIn),
    .taskMode   (taskMode),
    .subtaskMode(subtaskMode),
    .a          (a),
    .b          (b),
    .c          (c),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .errCount   (errCount),
    .failCfg    (failCfg),
    .failVec    (failVec),
    .failValid  (failValid)
  );

  // Behavioural gate datapath.
  always_comb begin
    l1In = 1'b0;
    l2In = 1'b0;
    xIn  = 1'b0;
    yIn  = 1'b0;
    zIn  = 1'b0;
    if (!taskMode) begin
      l1In = subtaskMode[0] ? (a | b) : (a & b);
      case (subtaskMode)
        2'd0:    l2In = l1In & c;
        2'd1:    l2In = l1In | c;
        2'd2:    l2In = ~(l1In & c);
        default: l2In = ~(l1In | c);
      endcase
    end else begin
      yIn = a | b;
      zIn = a | ~b;
      xIn = a | ~b;
    end
    if (fault_l2) l2In = 1'b0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [5:0] pins();
    return {taskMode, subtaskMode, a, b, c};
  endfunction

  // Drive-pin pattern for sweep vector k (0..39): bit 5 taskMode, 4:3 subtaskMode, 2:0 abc.
  function automatic int exp_pins(input int k);
    return (k < 32) ? (((k / 8) << 3) | (k % 8)) : (32 | (k % 8));
  endfunction

  function automatic logic [21:0] outs();
    return {taskMode, subtaskMode, a, b, c, busy, done, pass,
            errCount, failCfg, failVec, failValid};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; start is high for cycle c0 and captured at edge c0+1.
  task automatic start_sweep(output int c0);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic expect_done(input int edge_no, input int err, input int fcfg,
                             input int fvec, input int fvalid, input int pass_v);
    exp_t e;
    e.edge_no = edge_no;
    e.err     = err;
    e.fcfg    = fcfg;
    e.fvec    = fvec;
    e.fvalid  = fvalid;
    e.pass_v  = pass_v;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d done events pending, expected 0 after %0d cycles",
               sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: compares each rising edge of done against the scoreboard.
  initial begin : monitor
    logic done_q;
    exp_t e;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: done rose at cycle %0d, expected no done", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.edge_no);
          check("done_errCount", 32'(errCount), e.err);
          check("done_failValid", 32'(failValid), e.fvalid);
          check("done_failCfg", 32'(failCfg), e.fcfg);
          check("done_failVec", 32'(failVec), e.fvec);
          check("done_pass", 32'(pass), e.pass_v);
          check("done_busy", 32'(busy), 0);
        end
      end
      done_q = done;
    end
  end

  initial begin : stimulus
    int c0;
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    stepMode = 1'b0;
    step     = 1'b0;
    fault_l2 = 1'b0;

    // Reset state.
    #12;
    check("reset_outputs", 32'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(2);
    check("idle_outputs", 32'(outs()), 0);

    // Free-run sweep with a golden datapath.
    start_sweep(c0);
    check("apply_busy", 32'(busy), 1);
    check("apply_vec0_pins", 32'(pins()), 0);
    expect_done(c0 + SWEEP, 0, 0, 0, 0, 1);
    drain(260);
    check("done_last_vec_pins", 32'(pins()), exp_pins(39));

    // l2 stuck at 0: 1+7+7+1+0 failures, first at cfg 0 vec 7.
    fault_l2 = 1'b1;
    start_sweep(c0);
    expect_done(c0 + SWEEP, 16, 0, 7, 1, 0);
    drain(260);
    fault_l2 = 1'b0;

    // Step mode: vectors advance one at a time, only on step.
    stepMode = 1'b1;
    start_sweep(c0);
    tick(56);
    check("hold_vec0_pins", 32'(pins()), exp_pins(0));
    check("hold_vec0_busy", 32'(busy), 1);
    check("hold_vec0_done", 32'(done), 0);
    for (int k = 1; k < 40; k++) begin
      if (k == 39) expect_done(cyc + 6, 0, 0, 0, 0, 1);
      pulse_step();
      if (k < 39) begin
        tick(7);
        check("step_vec_pins", 32'(pins()), exp_pins(k));
      end
      if (k == 10) begin
        tick(50);
        check("hold_idle_vec_pins", 32'(pins()), exp_pins(10));
        check("hold_idle_busy", 32'(busy), 1);
      end
    end
    drain(20);
    stepMode = 1'b0;

    // Abort during cfg 2 vec 3 (sweep vector 19), with start asserted alongside.
    fault_l2 = 1'b1;
    start_sweep(c0);
    tick(96);
    check("pre_abort_pins", 32'(pins()), exp_pins(19));
    check("pre_abort_errCount", 32'(errCount), 11);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort_pins", 32'(pins()), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_errCount_held", 32'(errCount), 11);
    check("abort_failValid_held", 32'(failValid), 1);
    check("abort_failVec_held", 32'(failVec), 7);
    tick(3);
    check("abort_stays_idle", 32'(busy), 0);
    fault_l2 = 1'b0;
    start_sweep(c0);
    check("restart_errCount_cleared", 32'(errCount), 0);
    check("restart_failValid_cleared", 32'(failValid), 0);
    check("restart_pins", 32'(pins()), 0);
    check("restart_busy", 32'(busy), 1);
    expect_done(c0 + SWEEP, 0, 0, 0, 0, 1);
    drain(260);

    // Asynchronous reset mid-APPLY of vector 12 (cfg 1 vec 4).
    fault_l2 = 1'b1;
    start_sweep(c0);
    tick(60);
    check("pre_reset_pins", 32'(pins()), exp_pins(12));
    check("pre_reset_errCount", 32'(errCount), 4);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'(outs()), 0);
    @(negedge clk);
    rst = 1'b0;
    fault_l2 = 1'b0;
    pulse_step();
    tick(3);
    check("post_reset_step_ignored", 32'(outs()), 0);

    // start during APPLY and step in free-run are ignored.
    start_sweep(c0);
    expect_done(c0 + SWEEP, 0, 0, 0, 0, 1);
    tick(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tick(15);
    pulse_step();
    tick(2);
    pulse_step();
    check("free_run_busy", 32'(busy), 1);
    drain(260);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
